// File: rtl/bus_arbiter_if.sv
// Request/response channel shared by the two bus masters and the slave bus.
// The master modport drives a request; the slave modport answers it.
interface bus_arbiter_if;
   logic        valid;
   logic        instr;
   logic        writeEnable;
   logic [31:0] address;
   logic [31:0] dataOut;
   logic [31:0] dataIn;
   logic        ready;

   modport master (
      output valid, instr, writeEnable, address, dataOut,
      input  dataIn, ready
   );

   modport slave (
      input  valid, instr, writeEnable, address, dataOut,
      output dataIn, ready
   );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter onto one slave bus, with one-cycle arbitration.
// Optional transaction timeout is enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic          clk,
   input  logic          reset,
   bus_arbiter_if.slave  m0,
   bus_arbiter_if.slave  m1,
   bus_arbiter_if.master bus,
   output logic [1:0]    grant,
   output logic          timeout
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state, state_next;
   logic [1:0]  grant_next;
   logic        last_owner, last_owner_next;  // 0 = m0, 1 = m1
   logic        sel_valid, sel_instr, sel_we;
   logic [31:0] sel_address, sel_data;
   logic        expire_hit;
   logic        expire;

   always_comb begin
      if (grant[1]) begin
         sel_valid   = m1.valid;
         sel_instr   = m1.instr;
         sel_we      = m1.writeEnable;
         sel_address = m1.address;
         sel_data    = m1.dataOut;
      end else begin
         sel_valid   = m0.valid;
         sel_instr   = m0.instr;
         sel_we      = m0.writeEnable;
         sel_address = m0.address;
         sel_data    = m0.dataOut;
      end
   end

`ifdef BUS_ARBITER_TIMEOUT_EN
   localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

   logic [CNT_W-1:0] busy_count;

   // Counts BUSY cycles that passed without a slave response; held at zero in IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_count <= '0;
      end else if (state != BUSY) begin
         busy_count <= '0;
      end else if (!bus.ready) begin
         busy_count <= busy_count + CNT_W'(1);
      end
   end

   assign expire_hit = (busy_count == CNT_W'(TIMEOUT_CYCLES));
`else
   assign expire_hit = 1'b0;
`endif

   always_comb begin
      state_next      = state;
      grant_next      = grant;
      last_owner_next = last_owner;
      expire          = 1'b0;
      bus.valid       = 1'b0;
      bus.instr       = 1'b0;
      bus.writeEnable = 1'b0;
      bus.address     = '0;
      bus.dataOut     = '0;
      m0.ready        = 1'b0;
      m0.dataIn       = '0;
      m1.ready        = 1'b0;
      m1.dataIn       = '0;

      case (state)
         IDLE: begin
            if (m0.valid || m1.valid) begin
               state_next = BUSY;
               if (m0.valid && m1.valid) begin
                  grant_next = last_owner ? 2'b01 : 2'b10;
               end else begin
                  grant_next = m0.valid ? 2'b01 : 2'b10;
               end
            end
         end

         BUSY: begin
            // A completing slave wins over abort, and abort wins over timeout.
            expire = !bus.ready && sel_valid && expire_hit;
            if (!expire) begin
               bus.valid       = sel_valid;
               bus.instr       = sel_instr;
               bus.writeEnable = sel_we;
               bus.address     = sel_address;
               bus.dataOut     = sel_data;
            end
            if (grant[1]) begin
               m1.ready  = bus.ready | expire;
               m1.dataIn = expire ? 32'hFFFF_FFFF : bus.dataIn;
            end else begin
               m0.ready  = bus.ready | expire;
               m0.dataIn = expire ? 32'hFFFF_FFFF : bus.dataIn;
            end
            if (bus.ready || !sel_valid || expire) begin
               state_next = IDLE;
               grant_next = 2'b00;
               if (bus.ready || expire) begin
                  last_owner_next = grant[1];
               end
            end
         end

         default: begin
            state_next = IDLE;
            grant_next = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         grant      <= 2'b00;
         last_owner <= 1'b1;
      end else begin
         state      <= state_next;
         grant      <= grant_next;
         last_owner <= last_owner_next;
      end
   end

   assign timeout = expire;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a table of directed cycles, hand-written corner sequences,
// and a randomized run scored against a transaction-level reference model.
`timescale 1ns/1ps
module tb_bus_arbiter;

`ifdef BUS_ARBITER_TIMEOUT_EN
   localparam int unsigned TO = 4;
`else
   localparam int unsigned TO = 255;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] grant;
   logic       timeout;

   bus_arbiter_if m0_if ();
   bus_arbiter_if m1_if ();
   bus_arbiter_if bus_if ();

   bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk     (clk),
      .reset   (reset),
      .m0      (m0_if),
      .m1      (m1_if),
      .bus     (bus_if),
      .grant   (grant),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Applies one cycle of control inputs on the falling edge and settles.
   task automatic step(input logic r, input logic v0, input logic v1, input logic rdy);
      @(negedge clk);
      reset        = r;
      m0_if.valid  = v0;
      m1_if.valid  = v1;
      bus_if.ready = rdy;
      #1;
   endtask

   typedef struct {
      logic        rst;
      logic        v0;
      logic        v1;
      logic        rdy;
      logic [1:0]  g;
      logic        bv;
      logic        r0;
      logic        r1;
      logic [31:0] addr;
   } vec_t;

   vec_t tbl[17];

   // Reference model state: owner -1 = bus free, otherwise index of the served master.
   int   owner;
   int   last;
   int   waited;
   logic        v[2];
   logic        ins[2];
   logic        we[2];
   logic [31:0] a[2];
   logic [31:0] d[2];
   logic        rdy;
   logic [31:0] din;
   logic        expire;
   logic [1:0]  eg;
   logic        ebv, ei, ewe, et;
   logic [31:0] ea, edo;
   logic        er[2];
   logic [31:0] ed[2];

   initial begin
      reset              = 1'b0;
      m0_if.valid        = 1'b0;
      m0_if.instr        = 1'b0;
      m0_if.writeEnable  = 1'b0;
      m0_if.address      = 32'h0000_0100;
      m0_if.dataOut      = 32'h0;
      m1_if.valid        = 1'b0;
      m1_if.instr        = 1'b1;
      m1_if.writeEnable  = 1'b0;
      m1_if.address      = 32'h0000_2000;
      m1_if.dataOut      = 32'h5555_5555;
      bus_if.ready       = 1'b0;
      bus_if.dataIn      = 32'hDEAD_BEEF;

      //            rst   v0    v1    rdy   grant  bv    r0    r1    address
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 32'h100};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 32'h100};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 32'h100};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 32'h100};
      tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 32'h2000};
      tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 32'h2000};
      tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 32'h100};
      tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 32'h2000};
      tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};

      for (int i = 0; i < 17; i++) begin
         step(tbl[i].rst, tbl[i].v0, tbl[i].v1, tbl[i].rdy);
         check($sformatf("tbl%0d grant", i), grant, tbl[i].g);
         check($sformatf("tbl%0d busValid", i), bus_if.valid, tbl[i].bv);
         check($sformatf("tbl%0d address", i), bus_if.address, tbl[i].addr);
         check($sformatf("tbl%0d m0Ready", i), m0_if.ready, tbl[i].r0);
         check($sformatf("tbl%0d m1Ready", i), m1_if.ready, tbl[i].r1);
         check($sformatf("tbl%0d m0DataIn", i), m0_if.dataIn, tbl[i].g[0] ? 32'hDEAD_BEEF : 32'h0);
         check($sformatf("tbl%0d m1DataIn", i), m1_if.dataIn, tbl[i].g[1] ? 32'hDEAD_BEEF : 32'h0);
         check($sformatf("tbl%0d timeout", i), timeout, 1'b0);
      end

      // m0 completes alone, so m1 wins the following tie with its write.
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      check("solo m0Ready", m0_if.ready, 1'b1);
      m0_if.writeEnable = 1'b1;
      m0_if.dataOut     = 32'hAAAA_AAAA;
      m1_if.instr       = 1'b0;
      m1_if.writeEnable = 1'b1;
      m1_if.dataOut     = 32'h1234_5678;
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("wr idle grant", grant, 2'b00);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("wr grant", grant, 2'b10);
      check("wr busValid", bus_if.valid, 1'b1);
      check("wr writeEnable", bus_if.writeEnable, 1'b1);
      check("wr instr", bus_if.instr, 1'b0);
      check("wr address", bus_if.address, 32'h0000_2000);
      check("wr dataOut", bus_if.dataOut, 32'h1234_5678);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      check("wr m1Ready", m1_if.ready, 1'b1);
      check("wr m0Ready", m0_if.ready, 1'b0);
      check("wr m0DataIn", m0_if.dataIn, 32'h0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check("wr gap grant", grant, 2'b00);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check("m0 next grant", grant, 2'b01);
      check("m0 next address", bus_if.address, 32'h0000_0100);
      check("m0 next dataOut", bus_if.dataOut, 32'hAAAA_AAAA);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      check("m0 next m0Ready", m0_if.ready, 1'b1);
      m0_if.writeEnable = 1'b0;

      // m1 granted then withdraws: abort leaves lastOwner at m0.
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("abort grant", grant, 2'b10);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check("abort busValid", bus_if.valid, 1'b0);
      check("abort m1Ready", m1_if.ready, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("abort idle grant", grant, 2'b00);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("abort retie grant", grant, 2'b10);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      check("abort retie m1Ready", m1_if.ready, 1'b1);

      // Reset while m0 holds the bus.
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check("pre-reset grant", grant, 2'b01);
      @(negedge clk);
      reset        = 1'b0;
      bus_if.ready = 1'b1;
      #1;
      check("rst grant", grant, 2'b00);
      check("rst busValid", bus_if.valid, 1'b0);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) step(1'b0, 1'b1, 1'b1, 1'b1);
         check($sformatf("rst%0d m0Ready", k), m0_if.ready, 1'b0);
         check($sformatf("rst%0d m1Ready", k), m1_if.ready, 1'b0);
      end
      step(1'b1, 1'b1, 1'b0, 1'b1);
      check("post-rst idle m0Ready", m0_if.ready, 1'b0);
      check("post-rst idle grant", grant, 2'b00);

      // Slave never answers.
      for (int k = 1; k <= int'(TO); k++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0);
         check($sformatf("wait%0d grant", k), grant, 2'b01);
         check($sformatf("wait%0d busValid", k), bus_if.valid, 1'b1);
         check($sformatf("wait%0d timeout", k), timeout, 1'b0);
         check($sformatf("wait%0d m0Ready", k), m0_if.ready, 1'b0);
      end
`ifdef BUS_ARBITER_TIMEOUT_EN
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check("to pulse", timeout, 1'b1);
      check("to m0Ready", m0_if.ready, 1'b1);
      check("to m0DataIn", m0_if.dataIn, 32'hFFFF_FFFF);
      check("to m1Ready", m1_if.ready, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("to after pulse", timeout, 1'b0);
      check("to after m0Ready", m0_if.ready, 1'b0);
      check("to after grant", grant, 2'b00);
`else
      for (int k = 0; k < 60; k++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0);
         check($sformatf("hold%0d busValid", k), bus_if.valid, 1'b1);
         check($sformatf("hold%0d timeout", k), timeout, 1'b0);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("hold drop busValid", bus_if.valid, 1'b0);
`endif

      // Randomized run against the reference model.
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      owner  = -1;
      last   = 1;
      waited = 0;
      for (int n = 0; n < 800; n++) begin
         @(negedge clk);
         for (int m = 0; m < 2; m++) begin
            v[m]   = ($urandom_range(0, 3) != 0);
            ins[m] = $urandom_range(0, 1) == 1;
            we[m]  = $urandom_range(0, 1) == 1;
            a[m]   = $urandom;
            d[m]   = $urandom;
         end
         rdy = ($urandom_range(0, 2) == 0);
         din = $urandom;
         m0_if.valid = v[0]; m0_if.instr = ins[0]; m0_if.writeEnable = we[0];
         m0_if.address = a[0]; m0_if.dataOut = d[0];
         m1_if.valid = v[1]; m1_if.instr = ins[1]; m1_if.writeEnable = we[1];
         m1_if.address = a[1]; m1_if.dataOut = d[1];
         bus_if.ready = rdy;
         bus_if.dataIn = din;
         #1;

         expire = 1'b0;
         eg = 2'b00; ebv = 1'b0; ei = 1'b0; ewe = 1'b0; ea = '0; edo = '0;
         er[0] = 1'b0; er[1] = 1'b0; ed[0] = '0; ed[1] = '0;
         if (owner >= 0) begin
`ifdef BUS_ARBITER_TIMEOUT_EN
            expire = !rdy && v[owner] && (waited == int'(TO));
`endif
            if (!expire) begin
               ebv = v[owner]; ei = ins[owner]; ewe = we[owner];
               ea = a[owner]; edo = d[owner];
            end
            er[owner] = rdy || expire;
            ed[owner] = expire ? 32'hFFFF_FFFF : din;
            eg = (owner == 0) ? 2'b01 : 2'b10;
         end
         et = expire;

         check($sformatf("rnd%0d grant", n), grant, eg);
         check($sformatf("rnd%0d bus", n),
               {bus_if.valid, bus_if.instr, bus_if.writeEnable}, {ebv, ei, ewe});
         check($sformatf("rnd%0d address", n), bus_if.address, ea);
         check($sformatf("rnd%0d dataOut", n), bus_if.dataOut, edo);
         check($sformatf("rnd%0d ready", n), {m0_if.ready, m1_if.ready}, {er[0], er[1]});
         check($sformatf("rnd%0d m0DataIn", n), m0_if.dataIn, ed[0]);
         check($sformatf("rnd%0d m1DataIn", n), m1_if.dataIn, ed[1]);
         check($sformatf("rnd%0d timeout", n), timeout, et);

         if (owner < 0) begin
            if (v[0] && v[1]) owner = 1 - last;
            else if (v[0]) owner = 0;
            else if (v[1]) owner = 1;
            waited = 0;
         end else if (rdy || expire) begin
            last  = owner;
            owner = -1;
         end else if (!v[owner]) begin
            owner = -1;
         end else begin
            waited++;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 255, number of BUSY cycles without busReady before the transaction is aborted (used only with the timeout macro).
REQ-002 clk  in  1  system clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset: 0 = reset asserted.
REQ-004 m0Valid, m0Instr, m0WriteEnable  in  1 each  master 0 (CPU core) request, fetch flag, write flag.
REQ-005 m0Address, m0DataOut  in  32 each  master 0 address and write data.
REQ-006 m0DataIn  out  32; m0Ready  out  1  master 0 read data and completion strobe.
REQ-007 m1Valid, m1Instr, m1WriteEnable, m1Address, m1DataOut, m1DataIn, m1Ready  same widths and directions as master 0, for master 1 (DMA/debug).
REQ-008 busValid, busInstr, busWriteEnable  out  1 each; address, dataOut  out  32 each  shared slave bus request.
REQ-009 dataIn  in  32; busReady  in  1  shared slave bus response.
REQ-010 grant  out  2  one-hot current owner: 01 = m0, 10 = m1, 00 = none.
REQ-011 timeout  out  1  one-cycle pulse when a transaction is aborted.

Function
REQ-012 FSM states: IDLE, BUSY; grant and lastOwner are registered.
REQ-013 IDLE: if exactly one mXValid is 1, that master is granted; if both are 1, the master not equal to lastOwner is granted (round-robin); next state BUSY.
REQ-014 Arbitration latency: one cycle; the slave busValid rises the cycle after the request is first seen in IDLE.
REQ-015 BUSY: busValid, busInstr, busWriteEnable, address, dataOut are combinationally muxed from the granted master; the non-granted master sees Ready = 0 and DataIn = 0.
REQ-016 BUSY: granted mXReady = busReady and mXDataIn = dataIn, combinational; the non-granted master's request never reaches the slave.
REQ-017 BUSY with busReady = 1: transaction completes; lastOwner <= granted master, grant <= 00, next state IDLE.
REQ-018 Exactly one IDLE cycle separates back-to-back transactions; a master still holding Valid during that cycle is arbitrated again per REQ-013.
REQ-019 BUSY with granted mXValid = 0 and busReady = 0: abort; busValid drops the same cycle, next state IDLE, lastOwner unchanged.
REQ-020 In IDLE all bus outputs and both mXReady are 0; mXDataIn are 0.
REQ-021 busReady asserted in IDLE is ignored.
REQ-022 Request and busReady in the same cycle as a completion: completion takes priority, the new request waits for IDLE.

Reset
REQ-023 reset = 0 forces the next state to IDLE asynchronously, grant = 00, lastOwner = m1 (so m0 wins the first tie), timeout = 0, and the timeout counter = 0.
REQ-024 Reset asserted in BUSY abandons the transaction; no Ready is issued to either master.
REQ-025 After reset deassertion, the first arbitration occurs on the first rising edge with reset = 1.

Configuration
REQ-026 Macro BUS_ARBITER_TIMEOUT_EN defined: an 8- to 32-bit counter clears on entry to BUSY and increments each BUSY cycle without busReady; when it reaches TIMEOUT_CYCLES, the arbiter pulses timeout and the granted mXReady for one cycle with mXDataIn = 32'hFFFFFFFF, then returns to IDLE.
REQ-027 Macro BUS_ARBITER_TIMEOUT_EN not defined: no counter exists, timeout is tied to 0, and BUSY lasts indefinitely until busReady or an abort.

Verification
REQ-028 reset = 0 mid-BUSY (m0 granted) -> grant = 00 and busValid = 0 immediately, and neither m0Ready nor m1Ready ever pulses.
REQ-029 m0Valid = 1 only, m0Address = 0x100, read, with busReady after 3 cycles and dataIn = 0xDEADBEEF -> busValid rises 1 cycle late, address = 0x100, m0Ready = 1 with m0DataIn = 0xDEADBEEF, m1Ready stays 0.
REQ-030 m0Valid and m1Valid held high for four transactions after reset -> grant sequence m0, m1, m0, m1, with one IDLE cycle between transactions.
REQ-031 m1 write of 0x12345678 to 0x2000 while m0 also requests -> the slave sees only the granted master's fields, the m1 write appears intact, and m0 is served next.
REQ-032 Granted m1 drops m1Valid before busReady -> busValid = 0 in the same cycle, state IDLE, and the next tie is still won per the unchanged lastOwner.
REQ-033 BUS_ARBITER_TIMEOUT_EN defined, TIMEOUT_CYCLES = 4, busReady held 0 -> after 4 BUSY cycles timeout = 1 and m0Ready = 1 with 0xFFFFFFFF for exactly one cycle; macro undefined -> busValid stays 1 indefinitely.
